variable_depth_reg_file: RTL and testbench

VARIABLE_DEPTH_REG_FILE -- requirements
Module: variable_depth_reg_file

---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/reg_file_read_port.sv | 80 ++++++++
 rtl/variable_depth_reg_file.sv | 100 ++++++++++
 tb/tb_variable_depth_reg_file.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and the byte-lane merge used by the write path and the read bypass.
package reg_file_pkg;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned MAX_LANES = 64;
  localparam int unsigned MAX_W     = LANE_W * MAX_LANES;

  // Callers zero-extend narrower words into MAX_W and truncate the result back.
  function automatic logic [MAX_W-1:0] lane_merge(
    input logic [MAX_W-1:0]     old_word,
    input logic [MAX_W-1:0]     new_word,
    input logic [MAX_LANES-1:0] mask
  );
    logic [MAX_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (mask[i]) begin
        merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: range check, write-first bypass, output registers and valid pulse.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LANES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [WIDTH-1:0]  mem_word_i,
  input  logic              mem_init_i,
  input  logic              wr_fire_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [LANES-1:0]  wr_mask_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_init_o,
  output logic              rd_valid_o
);

  localparam int unsigned          AW1     = ADDR_W + 1;
  localparam logic [ADDR_W:0]      DEPTH_A = AW1'(DEPTH);

  logic             in_range_c;
  logic             hit_c;
  logic [WIDTH-1:0] word_c;
  logic             init_c;
  logic [WIDTH-1:0] data_d, data_q;
  logic             init_d, init_q;
  logic             valid_d, valid_q;

  // Select what this port would see after the current edge's write.
  always_comb begin
    in_range_c = ({1'b0, rd_addr_i} < DEPTH_A);
    hit_c      = wr_fire_i && (wr_addr_i == rd_addr_i);
    word_c     = '0;
    init_c     = 1'b0;
    if (in_range_c) begin
      if (hit_c) begin
        word_c = WIDTH'(lane_merge(MAX_W'(mem_word_i), MAX_W'(wr_data_i),
                                   MAX_LANES'(wr_mask_i)));
        init_c = 1'b1;
      end else begin
        word_c = mem_word_i;
        init_c = mem_init_i;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    init_d  = init_q;
    valid_d = rd_en_i;
    if (rd_en_i) begin
      data_d = word_c;
      init_d = init_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      init_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      init_q  <= init_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_init_o  = init_q;
  assign rd_valid_o = valid_q;

endmodule

// File: rtl/variable_depth_reg_file.sv
// Byte-masked register file with one write port and two independent registered read ports.
module variable_depth_reg_file
  import reg_file_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned DEPTH  = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned LANES  = WIDTH / LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [LANES-1:0]  write_mask,
  input  logic              read_enable_a,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic              read_enable_b,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  read_data_a,
  output logic [WIDTH-1:0]  read_data_b,
  output logic              read_valid_a,
  output logic              read_valid_b,
  output logic              read_init_a,
  output logic              read_init_b
);

  localparam int unsigned     AW1     = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_A = AW1'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] init_q;
  logic             wr_fire_c;
  logic [WIDTH-1:0] wr_word_c;

  // Out-of-range writes never fire, so they leave data and init flags untouched.
  always_comb begin
    wr_fire_c = write_enable && ({1'b0, write_addr} < DEPTH_A);
    wr_word_c = '0;
    if (wr_fire_c) begin
      wr_word_c = WIDTH'(lane_merge(MAX_W'(mem_q[write_addr]), MAX_W'(write_data),
                                    MAX_LANES'(write_mask)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
      init_q <= '0;
    end else if (wr_fire_c) begin
      mem_q[write_addr]  <= wr_word_c;
      init_q[write_addr] <= 1'b1;
    end
  end

  reg_file_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .LANES (LANES)
  ) u_port_a (
    .clk       (clk),
    .reset     (reset),
    .rd_en_i   (read_enable_a),
    .rd_addr_i (read_addr_a),
    .mem_word_i(mem_q[read_addr_a]),
    .mem_init_i(init_q[read_addr_a]),
    .wr_fire_i (wr_fire_c),
    .wr_addr_i (write_addr),
    .wr_data_i (write_data),
    .wr_mask_i (write_mask),
    .rd_data_o (read_data_a),
    .rd_init_o (read_init_a),
    .rd_valid_o(read_valid_a)
  );

  reg_file_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .LANES (LANES)
  ) u_port_b (
    .clk       (clk),
    .reset     (reset),
    .rd_en_i   (read_enable_b),
    .rd_addr_i (read_addr_b),
    .mem_word_i(mem_q[read_addr_b]),
    .mem_init_i(init_q[read_addr_b]),
    .wr_fire_i (wr_fire_c),
    .wr_addr_i (write_addr),
    .wr_data_i (write_data),
    .wr_mask_i (write_mask),
    .rd_data_o (read_data_b),
    .rd_init_o (read_init_b),
    .rd_valid_o(read_valid_b)
  );

endmodule

// File: tb/tb_variable_depth_reg_file.sv
// Directed and random checks of variable_depth_reg_file (DEPTH=20) against an array model.
module tb_variable_depth_reg_file;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 20;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LANES  = 4;

  logic              clk;
  logic              reset;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [WIDTH-1:0]  write_data;
  logic [LANES-1:0]  write_mask;
  logic              read_enable_a, read_enable_b;
  logic [ADDR_W-1:0] read_addr_a, read_addr_b;
  logic [WIDTH-1:0]  read_data_a, read_data_b;
  logic              read_valid_a, read_valid_b;
  logic              read_init_a, read_init_b;

  variable_depth_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_mask   (write_mask),
    .read_enable_a(read_enable_a),
    .read_addr_a  (read_addr_a),
    .read_enable_b(read_enable_b),
    .read_addr_b  (read_addr_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b),
    .read_valid_a (read_valid_a),
    .read_valid_b (read_valid_b),
    .read_init_a  (read_init_a),
    .read_init_b  (read_init_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays plus the expected output values.
  logic [WIDTH-1:0] m_mem  [DEPTH];
  logic             m_init [DEPTH];
  logic [WIDTH-1:0] e_data_a, e_data_b;
  logic             e_init_a, e_init_b, e_valid_a, e_valid_b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_a"},  read_data_a,        e_data_a);
    chk({tag, ".init_a"},  32'(read_init_a),   32'(e_init_a));
    chk({tag, ".valid_a"}, 32'(read_valid_a),  32'(e_valid_a));
    chk({tag, ".data_b"},  read_data_b,        e_data_b);
    chk({tag, ".init_b"},  32'(read_init_b),   32'(e_init_b));
    chk({tag, ".valid_b"}, 32'(read_valid_b),  32'(e_valid_b));
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i]  = '0;
      m_init[i] = 1'b0;
    end
    e_data_a = '0; e_init_a = 1'b0; e_valid_a = 1'b0;
    e_data_b = '0; e_init_b = 1'b0; e_valid_b = 1'b0;
  endtask

  // Write lands first, then both reads observe the updated array.
  task automatic model_edge();
    int wa, ra, rb;
    wa = int'(write_addr);
    ra = int'(read_addr_a);
    rb = int'(read_addr_b);
    if (write_enable && wa < int'(DEPTH)) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (write_mask[l]) m_mem[wa][8*l +: 8] = write_data[8*l +: 8];
      end
      m_init[wa] = 1'b1;
    end
    e_valid_a = read_enable_a;
    if (read_enable_a) begin
      e_data_a = (ra < int'(DEPTH)) ? m_mem[ra]  : '0;
      e_init_a = (ra < int'(DEPTH)) ? m_init[ra] : 1'b0;
    end
    e_valid_b = read_enable_b;
    if (read_enable_b) begin
      e_data_b = (rb < int'(DEPTH)) ? m_mem[rb]  : '0;
      e_init_b = (rb < int'(DEPTH)) ? m_init[rb] : 1'b0;
    end
  endtask

  task automatic cycle(input string tag);
    if (!reset) model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    write_enable  = 1'b0; write_addr  = '0; write_data = '0; write_mask = '0;
    read_enable_a = 1'b0; read_addr_a = '0;
    read_enable_b = 1'b0; read_addr_b = '0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] m);
    write_enable = 1'b1; write_addr = a; write_data = d; write_mask = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #12;
    check_all("reset_hold");
    read_enable_a = 1'b1; read_addr_a = 5'd2; wr(5'd2, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    check_all("reset_edge");
    reset = 1'b0;
    idle();
    cycle("post_release");

    // Unwritten entry reads as zero, not initialised.
    read_enable_a = 1'b1; read_addr_a = 5'd5;
    cycle("rd5");
    chk("rd5_data", read_data_a, 32'h0);
    chk("rd5_init", 32'(read_init_a), 32'd0);
    chk("rd5_valid", 32'(read_valid_a), 32'd1);
    idle();
    cycle("rd5_after");
    chk("rd5_valid_drop", 32'(read_valid_a), 32'd0);

    // Two overlapping masked writes to entry 3.
    wr(5'd3, 32'hDEADBEEF, 4'hF);
    cycle("wr3_full");
    wr(5'd3, 32'h11223344, 4'h5);
    cycle("wr3_mask");
    idle();
    read_enable_a = 1'b1; read_addr_a = 5'd3;
    cycle("rd3");
    chk("rd3_data", read_data_a, 32'hDE22BE44);
    chk("rd3_init", 32'(read_init_a), 32'd1);

    // Same-cycle write and dual read of entry 7.
    idle();
    wr(5'd7, 32'hA5A5A5A5, 4'hF);
    read_enable_a = 1'b1; read_addr_a = 5'd7;
    read_enable_b = 1'b1; read_addr_b = 5'd7;
    cycle("byp7");
    chk("byp7_a", read_data_a, 32'hA5A5A5A5);
    chk("byp7_b", read_data_b, 32'hA5A5A5A5);
    chk("byp7_init_a", 32'(read_init_a), 32'd1);
    chk("byp7_init_b", 32'(read_init_b), 32'd1);
    wr(5'd7, 32'h0000FF00, 4'h2);
    cycle("byp7_partial");
    chk("byp7p_a", read_data_a, 32'hA5A5FFA5);
    chk("byp7p_b", read_data_b, 32'hA5A5FFA5);

    // Zero-mask write only sets the init flag.
    idle();
    wr(5'd9, 32'hFFFFFFFF, 4'h0);
    read_enable_a = 1'b1; read_addr_a = 5'd9;
    cycle("mask0");
    chk("mask0_data", read_data_a, 32'h0);
    chk("mask0_init", 32'(read_init_a), 32'd1);

    // Out-of-range write and reads.
    idle();
    wr(5'd4, 32'h04040404, 4'hF);
    cycle("wr4");
    wr(5'd25, 32'hFFFFFFFF, 4'hF);
    cycle("wr25");
    idle();
    read_enable_a = 1'b1; read_addr_a = 5'd25;
    read_enable_b = 1'b1; read_addr_b = 5'd4;
    cycle("oor");
    chk("oor_data", read_data_a, 32'h0);
    chk("oor_init", 32'(read_init_a), 32'd0);
    chk("oor_valid", 32'(read_valid_a), 32'd1);
    chk("oor_keep4", read_data_b, 32'h04040404);
    read_addr_b = 5'd9;
    cycle("oor_alias9");
    chk("alias9_data", read_data_b, 32'h0);

    // Held outputs while port A is idle and entry 3 is rewritten.
    idle();
    read_enable_a = 1'b1; read_addr_a = 5'd3;
    cycle("hold_rd");
    read_enable_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr(5'd3, $urandom, 4'hF);
      cycle("hold");
      chk("hold_data", read_data_a, 32'hDE22BE44);
      chk("hold_valid", 32'(read_valid_a), 32'd0);
    end

    // Random traffic, with reads biased toward the written address.
    for (int n = 0; n < 400; n++) begin
      write_enable  = ($urandom_range(0, 3) != 0);
      write_addr    = 5'($urandom_range(0, 24));
      write_data    = $urandom;
      write_mask    = 4'($urandom_range(0, 15));
      read_enable_a = ($urandom_range(0, 3) != 0);
      read_addr_a   = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 24));
      read_enable_b = ($urandom_range(0, 3) != 0);
      read_addr_b   = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 24));
      cycle("rand");
    end

    // Reset asserted mid-cycle with traffic pending.
    idle();
    wr(5'd3, 32'hCAFEF00D, 4'hF);
    read_enable_a = 1'b1; read_addr_a = 5'd3;
    read_enable_b = 1'b1; read_addr_b = 5'd3;
    cycle("pre_rst");
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    cycle("rst_during");
    reset = 1'b0;
    idle();
    cycle("rst_release");
    read_enable_a = 1'b1; read_addr_a = 5'd3;
    cycle("rst_rd3");
    chk("rst_rd3_data", read_data_a, 32'h0);
    chk("rst_rd3_init", 32'(read_init_a), 32'd0);
    chk("rst_rd3_valid", 32'(read_valid_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
